mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 128, meaning data memory size in bytes (multiple of 4).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req  input  1  CPU access request, sampled only in IDLE.
REQ-005 SHALL have port we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 SHALL have port sext  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  store data, right-justified for byte/halfword.
REQ-010 SHALL have port rdata  output  32  load result, right-justified and extended.
REQ-011 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err  output  1  valid with done; 1 = access rejected.
REQ-014 SHALL have port Memaddr  output  32  word-aligned address to data memory.
REQ-015 SHALL have port Mwdata  output  32  write word to data memory.
REQ-016 SHALL have port MemRead  output  1  data memory read enable.
REQ-017 SHALL have port MemWrite  output  1  data memory write enable; memory writes on the rising edge when high.
REQ-018 SHALL have port Mrdata  input  32  combinational read word from data memory.

Function
REQ-019 SHALL implement FSM states IDLE, RD, WR, DONE.
REQ-020 SHALL, in IDLE with req=1, latch we/size/sext/addr/wdata and transition: error -> DONE; load -> RD; word store -> WR; byte/halfword store -> RD.
REQ-021 SHALL flag error when size=11, halfword addr[0]!=0, word addr[1:0]!=0, or addr >= MEM_SIZE; errored requests SHALL NOT assert MemRead or MemWrite.
REQ-022 SHALL ignore req while busy=1; no queueing.
REQ-023 SHALL, in RD, drive MemRead=1, Memaddr={addr[31:2],2'b00} and capture Mrdata into an internal word register at cycle end.
REQ-024 SHALL, in RD for a load, go to DONE; for a sub-word store, go to WR.
REQ-025 SHALL, in WR, drive MemWrite=1, same Memaddr; Mwdata = wdata for word stores, else captured word with target lane replaced; then go to DONE.
REQ-026 SHALL use big-endian lanes: byte offset 0 = bits[31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]; halfword offset 0 = [31:16], offset 2 = [15:0].
REQ-027 SHALL, in DONE, assert done=1 for exactly that cycle, then go to IDLE unconditionally.
REQ-028 SHALL update rdata at the RD->DONE edge of successful loads only; stores and errors leave rdata unchanged.
REQ-029 SHALL drive Memaddr, Mwdata to 0 and MemRead, MemWrite to 0 outside RD/WR (Mwdata nonzero only in WR).
REQ-030 SHALL give req-edge-to-done latency: error 1 cycle, load 2, word store 2, sub-word store 3.
REQ-031 SHALL hold err at 0 except during DONE of a rejected request.
REQ-032 SHALL accept a new req in the cycle immediately following DONE.

Reset
REQ-033 SHALL, on rising clk with rst_n=0, enter IDLE and clear rdata, internal registers; busy, done, err, MemRead, MemWrite, Memaddr, Mwdata all 0 afterwards.
REQ-034 SHALL, when rst_n=0 coincides with a WR cycle, still have MemWrite=1 at that edge (write lands); no done pulse follows.
REQ-035 SHALL ignore req on any edge where rst_n=0.

Verification
REQ-036 SHALL cover: word store addr=0x10 wdata=0x11223344, then word load 0x10 -> MemWrite one cycle, done 2 cycles after each req, rdata=0x11223344.
REQ-037 SHALL cover: after REQ-036, byte store addr=0x11 wdata=0xAA -> RD then WR with Mwdata=0x11AA3344; word load 0x10 returns 0x11AA3344.
REQ-038 SHALL cover: byte load 0x11 sext=1 -> rdata=0xFFFFFFAA; sext=0 -> 0x000000AA; halfword load 0x12 sext=1 -> 0x00003344.
REQ-039 SHALL cover: halfword load addr=0x13, word store addr=0x80, size=11 -> err=1 with done 1 cycle after req, MemRead/MemWrite never high, rdata unchanged.
REQ-040 SHALL cover: req held high continuously during a 3-cycle sub-word store -> exactly one access, second accepted only the cycle after done.
REQ-041 SHALL cover: rst_n=0 during RD of a sub-word store -> no WR cycle, memory unchanged, all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store bridge between a CPU port and a word-wide data memory.
// Sub-word stores use read-modify-write. Memory lanes are big-endian.
module mem_access_ctrl #(
   parameter int MEM_SIZE = 128
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] Memaddr,
   output logic [31:0] Mwdata,
   output logic        MemRead,
   output logic        MemWrite,
   input  logic [31:0] Mrdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RD   = 2'd1;
   localparam logic [1:0] WR   = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [31:0] MEM_LIM = 32'(MEM_SIZE);

   logic [1:0]  state;
   logic        we_q, sext_q, err_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q, word_q;
   logic        req_err;
   logic [7:0]  bsel;
   logic [15:0] hsel;
   logic [31:0] load_val, merged;

   always_comb begin
      req_err = 1'b0;
      case (size)
         2'b01:   if (addr[0])          req_err = 1'b1;
         2'b10:   if (addr[1:0] != 2'b00) req_err = 1'b1;
         2'b11:   req_err = 1'b1;
         default: ;
      endcase
      if (addr >= MEM_LIM) req_err = 1'b1;
   end

   // Lane select / extension of the word currently on Mrdata.
   always_comb begin
      case (addr_q[1:0])
         2'd0:    bsel = Mrdata[31:24];
         2'd1:    bsel = Mrdata[23:16];
         2'd2:    bsel = Mrdata[15:8];
         default: bsel = Mrdata[7:0];
      endcase
      hsel = addr_q[1] ? Mrdata[15:0] : Mrdata[31:16];
      case (size_q)
         2'b00:   load_val = sext_q ? {{24{bsel[7]}}, bsel} : {24'b0, bsel};
         2'b01:   load_val = sext_q ? {{16{hsel[15]}}, hsel} : {16'b0, hsel};
         default: load_val = Mrdata;
      endcase
   end

   // Captured word with the target lane replaced by the store data.
   always_comb begin
      merged = word_q;
      if (size_q == 2'b00) begin
         case (addr_q[1:0])
            2'd0:    merged[31:24] = wdata_q[7:0];
            2'd1:    merged[23:16] = wdata_q[7:0];
            2'd2:    merged[15:8]  = wdata_q[7:0];
            default: merged[7:0]   = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         merged[15:0] = wdata_q[15:0];
      end else begin
         merged[31:16] = wdata_q[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         sext_q  <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
         rdata   <= '0;
      end else begin
         case (state)
            IDLE: if (req) begin
               we_q    <= we;
               sext_q  <= sext;
               size_q  <= size;
               addr_q  <= addr;
               wdata_q <= wdata;
               err_q   <= req_err;
               if (req_err)                    state <= DONE;
               else if (!we || size != 2'b10)  state <= RD;
               else                            state <= WR;
            end
            RD: begin
               word_q <= Mrdata;
               if (we_q) begin
                  state <= WR;
               end else begin
                  rdata <= load_val;
                  state <= DONE;
               end
            end
            WR:      state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      busy     = (state != IDLE);
      done     = (state == DONE);
      err      = (state == DONE) && err_q;
      MemRead  = (state == RD);
      MemWrite = (state == WR);
      Memaddr  = (MemRead || MemWrite) ? {addr_q[31:2], 2'b00} : 32'h0;
      Mwdata   = 32'h0;
      if (MemWrite) Mwdata = (size_q == 2'b10) ? wdata_q : merged;
   end

endmodule
